// File: rtl/dmem_req_ctrl.sv
// rtl/dmem_req_ctrl.sv - registers pipeline load/store requests and sequences them onto mem_system
module dmem_req_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic [15:0] mem_Addr,
   output logic [15:0] mem_DataIn,
   output logic        mem_Rd,
   output logic        mem_Wr,
   input  logic [15:0] mem_DataOut,
   input  logic        mem_Done,
   input  logic        mem_Stall,
   input  logic        mem_CacheHit,
   input  logic        mem_err,
   input  logic        stats_clr,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        op_wr_q, op_wr_d;
   logic        err_seen_q, err_seen_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [15:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic        busy_q, busy_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_datain_q, mem_datain_d;
   logic        mem_rd_q, mem_rd_d;
   logic        mem_wr_q, mem_wr_d;
   logic [15:0] hit_count_q, hit_count_d;
   logic [15:0] miss_count_q, miss_count_d;

   logic        illegal;
   logic        done_err;
   logic        count_en;
   logic        stall_unused;

   assign stall_unused = mem_Stall;

   always_comb begin
      state_d      = state_q;
      op_wr_d      = op_wr_q;
      err_seen_d   = err_seen_q;
      tmo_cnt_d    = tmo_cnt_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_addr_d   = mem_addr_q;
      mem_datain_d = mem_datain_q;
      mem_rd_d     = 1'b0;
      mem_wr_d     = 1'b0;
      count_en     = 1'b0;
      illegal      = (req_rd == req_wr) | req_addr[0];
      done_err     = mem_err | err_seen_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               mem_addr_d   = req_addr;
               mem_datain_d = req_wdata;
               op_wr_d      = req_wr;
               if (illegal) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = 16'h0000;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d  = ISSUE;
                  mem_rd_d = req_rd;
                  mem_wr_d = req_wr;
               end
            end
         end
         ISSUE: begin
            state_d    = WAIT;
            tmo_cnt_d  = 8'd0;
            err_seen_d = 1'b0;
         end
         WAIT: begin
            err_seen_d = done_err;
            // A Done arriving on the last allowed cycle still completes normally.
            if (mem_Done) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = op_wr_q ? 16'h0000 : mem_DataOut;
               resp_err_d   = done_err;
               count_en     = ~done_err;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d      = DRAIN;
               resp_valid_d = 1'b1;
               resp_rdata_d = 16'h0000;
               resp_err_d   = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         DRAIN: begin
            if (mem_Done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);

      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (stats_clr) begin
         hit_count_d  = 16'h0000;
         miss_count_d = 16'h0000;
      end else if (count_en) begin
         if (mem_CacheHit) begin
            if (hit_count_q != 16'hFFFF) begin
               hit_count_d = hit_count_q + 16'd1;
            end
         end else if (miss_count_q != 16'hFFFF) begin
            miss_count_d = miss_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         op_wr_q      <= 1'b0;
         err_seen_q   <= 1'b0;
         tmo_cnt_q    <= 8'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 16'h0000;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b0;
         mem_addr_q   <= 16'h0000;
         mem_datain_q <= 16'h0000;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         hit_count_q  <= 16'h0000;
         miss_count_q <= 16'h0000;
      end else begin
         state_q      <= state_d;
         op_wr_q      <= op_wr_d;
         err_seen_q   <= err_seen_d;
         tmo_cnt_q    <= tmo_cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         busy_q       <= busy_d;
         mem_addr_q   <= mem_addr_d;
         mem_datain_q <= mem_datain_d;
         mem_rd_q     <= mem_rd_d;
         mem_wr_q     <= mem_wr_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;
   assign mem_Addr   = mem_addr_q;
   assign mem_DataIn = mem_datain_q;
   assign mem_Rd     = mem_rd_q;
   assign mem_Wr     = mem_wr_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb/tb_dmem_req_ctrl.sv - directed vector bench for dmem_req_ctrl with a small mem_system model
module tb_dmem_req_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_rd, req_wr;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err, busy;
   logic [15:0] resp_rdata, mem_Addr, mem_DataIn;
   logic        mem_Rd, mem_Wr;
   logic [15:0] mem_DataOut;
   logic        mem_Done, mem_Stall, mem_CacheHit, mem_err, stats_clr;
   logic [15:0] hit_count, miss_count;

   always #5 clk = ~clk;

   dmem_req_ctrl #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
      .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
      .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
      .mem_CacheHit(mem_CacheHit), .mem_err(mem_err),
      .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        hit;
      int          merr;    // 0 none, 1 with Done, 2 one pulse early in WAIT
      int          dly;     // Done asserted this many cycles after the Rd/Wr strobe
      int          lat;
      int          rdy;
      logic [15:0] rdata;
      logic        err;
      int          rdp;
      int          wrp;
      int          hitc;
      int          missc;
   } vec_t;

   vec_t        vecs[14];
   bit   [15:0] model[0:255];
   int          checks = 0;
   int          errors = 0;
   int          cur_row = -1;
   int          r_lat, r_rdy, r_rdp, r_wrp, r_addr_bad, r_resp_cnt;
   logic [15:0] r_rdata;
   logic        r_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h want %0h", name, cur_row, act, exp);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_addr", mem_Addr, 0);
      chk("rst_mem_datain", mem_DataIn, 0);
      chk("rst_mem_rd", mem_Rd, 0);
      chk("rst_mem_wr", mem_Wr, 0);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
   endtask

   task automatic run_txn(input vec_t v, input bit clr_on_done);
      int issue = -1;
      r_lat = -1; r_rdy = -1; r_rdp = 0; r_wrp = 0; r_addr_bad = 0; r_resp_cnt = 0;
      r_rdata = 16'h0; r_err = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_rd = v.rd; req_wr = v.wr;
      req_addr = v.addr; req_wdata = v.wdata;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         req_valid = 1'b0; mem_Done = 1'b0; mem_err = 1'b0;
         mem_CacheHit = 1'b0; stats_clr = 1'b0;
         if (mem_Rd) r_rdp++;
         if (mem_Wr) r_wrp++;
         if ((mem_Rd || mem_Wr) && issue < 0) begin
            issue = cyc;
            if (mem_Wr) model[mem_Addr[15:8]] = mem_DataIn;
         end
         if (issue >= 0 && mem_Addr !== v.addr) r_addr_bad++;
         if (resp_valid) begin
            r_resp_cnt++;
            if (r_lat < 0) begin
               r_lat = cyc; r_rdata = resp_rdata; r_err = resp_err;
            end
         end
         if (req_ready && r_lat >= 0) begin
            r_rdy = cyc;
            break;
         end
         if (issue >= 0 && cyc == issue + v.dly) begin
            mem_Done = 1'b1;
            mem_CacheHit = v.hit;
            mem_DataOut = v.rd ? model[v.addr[15:8]] : 16'hDEAD;
            mem_err = (v.merr == 1);
            stats_clr = clr_on_done;
         end
         if (issue >= 0 && cyc == issue + 1 && v.merr == 2) mem_err = 1'b1;
      end
      if (r_rdy < 0) chk("txn_timeout", 0, 1);
   endtask

   initial begin
      // rd wr addr wdata hit merr dly | lat rdy rdata err rdp wrp hitc missc
      vecs[0]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 0,  6,  8,  9, 16'h0000, 1'b0, 1, 0, 0, 1};
      vecs[1]  = '{1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 0,  6,  8,  9, 16'h0000, 1'b0, 0, 1, 0, 2};
      vecs[2]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 0,  2,  4,  5, 16'hBEEF, 1'b0, 1, 0, 1, 2};
      vecs[3]  = '{1'b1, 1'b0, 16'h0101, 16'h0000, 1'b1, 0,  0,  1,  2, 16'h0000, 1'b1, 0, 0, 1, 2};
      vecs[4]  = '{1'b1, 1'b1, 16'h0200, 16'h0000, 1'b1, 0,  0,  1,  2, 16'h0000, 1'b1, 0, 0, 1, 2};
      vecs[5]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, 1'b1, 0,  0,  1,  2, 16'h0000, 1'b1, 0, 0, 1, 2};
      vecs[6]  = '{1'b0, 1'b1, 16'h0301, 16'h5555, 1'b1, 0,  0,  1,  2, 16'h0000, 1'b1, 0, 0, 1, 2};
      vecs[7]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1,  2,  4,  5, 16'hBEEF, 1'b1, 1, 0, 1, 2};
      vecs[8]  = '{1'b0, 1'b1, 16'h0200, 16'h1234, 1'b1, 0,  3,  5,  6, 16'h0000, 1'b0, 0, 1, 2, 2};
      vecs[9]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 2,  3,  5,  6, 16'h1234, 1'b1, 1, 0, 2, 2};
      vecs[10] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 0,  2,  4,  5, 16'h1234, 1'b0, 1, 0, 3, 2};
      vecs[11] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 0, 70, 66, 72, 16'h0000, 1'b1, 1, 0, 3, 2};
      vecs[12] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 0, 64, 66, 67, 16'h0000, 1'b0, 1, 0, 3, 3};
      vecs[13] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 0, 65, 66, 67, 16'h0000, 1'b1, 1, 0, 3, 3};

      for (int i = 0; i < 256; i++) model[i] = 16'h0000;
      rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
      req_addr = 16'h0; req_wdata = 16'h0; mem_DataOut = 16'h0; mem_Done = 1'b0;
      mem_Stall = 1'b0; mem_CacheHit = 1'b0; mem_err = 1'b0; stats_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         cur_row = i;
         run_txn(vecs[i], 1'b0);
         chk("latency", r_lat, vecs[i].lat);
         chk("ready_back", r_rdy, vecs[i].rdy);
         chk("resp_rdata", r_rdata, vecs[i].rdata);
         chk("resp_err", r_err, vecs[i].err);
         chk("rd_pulses", r_rdp, vecs[i].rdp);
         chk("wr_pulses", r_wrp, vecs[i].wrp);
         chk("addr_held", r_addr_bad, 0);
         chk("resp_pulses", r_resp_cnt, 1);
         chk("hit_count", hit_count, vecs[i].hitc);
         chk("miss_count", miss_count, vecs[i].missc);
      end

      // Saturation: preload the hit counter just below full, then hit three times.
      cur_row = 100;
      @(negedge clk);
      force dut.hit_count_q = 16'hFFFE;
      repeat (2) @(negedge clk);
      release dut.hit_count_q;
      @(negedge clk);
      chk("preload_hit", hit_count, 16'hFFFE);
      for (int k = 0; k < 3; k++) begin
         run_txn(vecs[2], 1'b0);
         chk("sat_hit", hit_count, 16'hFFFF);
         chk("sat_rdata", r_rdata, 16'hBEEF);
      end
      chk("sat_miss", miss_count, 3);

      // stats_clr on the Done cycle of a counted miss wins over the increment.
      cur_row = 101;
      run_txn(vecs[12], 1'b1);
      chk("clr_hit", hit_count, 0);
      chk("clr_miss", miss_count, 0);
      chk("clr_err", r_err, 0);

      // Reset in WAIT abandons the request with no response.
      cur_row = 102;
      @(negedge clk);
      req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 16'h0500; req_wdata = 16'h7777;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_rd_strobe", mem_Rd, 1);
      repeat (2) @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_ready", req_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals();
      begin
         int stray = 0;
         int not_ready = 0;
         repeat (10) begin
            @(negedge clk);
            if (resp_valid) stray++;
            if (!req_ready) not_ready++;
         end
         chk("no_resp_after_rst", stray, 0);
         chk("ready_after_rst", not_ready, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_req_ctrl.md
Name: dmem_req_ctrl

Overview:
- Sits directly upstream of mem_system, between the processor MEM stage and the cache/memory subsystem.
- Accepts one load/store request per transaction via a valid/ready handshake and registers it.
- Drives mem_system's Addr/DataIn/Rd/Wr under that block's protocol: single-cycle Rd/Wr strobe, address held stable until Done.
- Returns read data and error status to the pipeline, detects misaligned/illegal requests and hung transactions, and keeps saturating hit/miss counters.

Parameters:
TIMEOUT_CYCLES, 64, cycles in WAIT without mem_Done before the transaction is aborted with error (range 8..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  pipeline request valid
req_rd  in  1  request is load
req_wr  in  1  request is store
req_addr  in  16  byte address
req_wdata  in  16  store data
req_ready  out  1  controller can accept a request
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  16  load data, valid with resp_valid
resp_err  out  1  error flag, valid with resp_valid
busy  out  1  transaction in flight; pipeline stall
mem_Addr  out  16  to mem_system Addr
mem_DataIn  out  16  to mem_system DataIn
mem_Rd  out  1  to mem_system Rd
mem_Wr  out  1  to mem_system Wr
mem_DataOut  in  16  from mem_system DataOut
mem_Done  in  1  from mem_system Done
mem_Stall  in  1  from mem_system Stall (monitor only)
mem_CacheHit  in  1  from mem_system CacheHit
mem_err  in  1  from mem_system err
stats_clr  in  1  clear hit/miss counters
hit_count  out  16  saturating cache-hit count
miss_count  out  16  saturating cache-miss count

Behaviour:
- Reset: state IDLE. req_ready=1. resp_valid=0, resp_rdata=0, resp_err=0, busy=0. mem_Addr=0, mem_DataIn=0, mem_Rd=0, mem_Wr=0. Counters=0. Timeout counter=0. Reset mid-transaction abandons it with no response.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: req_ready=1, busy=0.
  - Accept occurs on req_valid&req_ready.
  - Latch addr, wdata and op into mem_Addr/mem_DataIn/op regs.
  - Illegal request (req_rd&req_wr, or neither, or req_addr[0]=1) -> RESP with err=1; no mem access.
  - Otherwise -> ISSUE.
- ISSUE (exactly 1 cycle): mem_Rd or mem_Wr=1 per op; busy=1; -> WAIT; clear timeout counter.
- WAIT: mem_Rd=mem_Wr=0; mem_Addr/mem_DataIn held; busy=1; timeout counter increments each cycle.
  - mem_Done=1: capture mem_DataOut (loads; stores capture 0) into resp_rdata; err=mem_err OR'd with any mem_err seen during WAIT (sticky); -> RESP.
  - Done not seen and counter reaches TIMEOUT_CYCLES-1: err=1, resp_rdata=0 -> DRAIN.
  - mem_Done and timeout in the same cycle: Done wins.
- RESP (1 cycle): resp_valid=1 with registered rdata/err; busy=1; req_ready=0; -> IDLE. Earliest next accept is the following cycle.
- DRAIN: resp_valid=1 for the first cycle only (timeout error reported); busy=1; wait for mem_Done, discard its data; -> IDLE. mem_Addr held throughout.
- Latency: cache hit = accept(c0), ISSUE(c1), mem_Done at c3, resp_valid at c4. Illegal request = resp_valid at c1.
- Counters, updated on a mem_Done accepted in WAIT with err=0:
  - hit_count++ if mem_CacheHit, else miss_count++.
  - Saturate at 16'hFFFF.
  - stats_clr zeroes both and overrides a same-cycle increment.
- mem_Rd and mem_Wr are never both 1 and never asserted outside ISSUE.

Test Plan:
- Load 0x0100 into an empty cache -> single mem_Rd pulse, mem_Addr=0x0100 held until Done; resp_valid=1, resp_err=0, miss_count=1.
- Store 0x0100 data 0xBEEF, then load 0x0100 -> load hits, resp_rdata=0xBEEF, resp_valid exactly 4 cycles after accept; hit_count=1.
- Request with req_addr=0x0101, and separately one with req_rd=req_wr=1 -> resp_valid next cycle, resp_err=1, mem_Rd/mem_Wr never asserted, counters unchanged.
- Model mem_Done withheld for 70 cycles, TIMEOUT_CYCLES=64 -> resp_err=1 pulse after 64 WAIT cycles; req_ready stays 0 until the late Done, then returns to IDLE.
- Preload hit_count=16'hFFFE, issue 3 hits -> count stays 16'hFFFF. Assert stats_clr on the same cycle as a Done -> both counters read 0.
- Assert rst during WAIT -> next cycle all outputs at reset values, req_ready=1, and no resp_valid is produced for the abandoned request.
